line_window_gen: RTL and testbench
==================================

Name: line_window_gen

Overview:
- Receiving end of the line-aligned column stream produced by the line-alignment buffer.
- Each valid beat carries one image column of LINE_NUM vertically aligned pixels.
- The block shifts WIN_W consecutive columns into a LINE_NUM x WIN_W pixel window and emits it with valid, line-end and frame-end markers.
- Sits between line alignment and the 2-D kernel (filter/demosaic) stages.

Parameters:
- DATA_WIDTH, 14, bits per pixel.
- LINE_NUM, 3, aligned lines per input column (window height).
- WIN_W, 3, window width in columns; legal range 2 <= WIN_W <= IMAGE_WIDTH.
- IMAGE_WIDTH, 240, pixels (columns) per line.
- IMAGE_HEIGHT, 12, source image lines; aligned rows per frame = IMAGE_HEIGHT-LINE_NUM+1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  LINE_NUM*DATA_WIDTH  aligned column; lane r at [r*DATA_WIDTH +: DATA_WIDTH], lane 0 = oldest line.
- datain_valid  input  1  column valid; no backpressure, every valid beat is consumed.
- window_out  output  LINE_NUM*WIN_W*DATA_WIDTH  pixel (c,r) at [(c*LINE_NUM+r)*DATA_WIDTH +: DATA_WIDTH]; c=0 is the leftmost (oldest) column.
- window_valid  output  1  window_out valid this cycle.
- line_end  output  1  pulses with the last window of an aligned row.
- frame_end  output  1  pulses with the last window of the last aligned row.

Behaviour:
- Reset (rst=1 at rising edge): column shift registers, col_cnt, row_cnt, window_out, window_valid, line_end and frame_end all go to 0. Reset has priority over datain_valid.
- Column store: WIN_W registers of LINE_NUM*DATA_WIDTH bits.
  - On datain_valid=1: col[0] <= col[1], ..., col[WIN_W-1] <= data_in.
  - On datain_valid=0: all state holds; idle gaps of any length are legal mid-line.
- col_cnt, width $clog2(IMAGE_WIDTH), counts valid beats within the row:
  - Beat index k = current col_cnt (0..IMAGE_WIDTH-1).
  - Increments per beat; wraps IMAGE_WIDTH-1 -> 0.
- row_cnt, width $clog2(IMAGE_HEIGHT):
  - Increments when col_cnt wraps.
  - Wraps (IMAGE_HEIGHT-LINE_NUM) -> 0.
- Output, registered, latency 1 cycle:
  - On a beat with k >= WIN_W-1, the next cycle has window_valid=1 and window_out = the shift-register contents after that beat, i.e. columns k-WIN_W+1..k.
  - Otherwise window_valid=0 next cycle.
  - window_out holds its last value when window_valid=0.
- Windows per row = IMAGE_WIDTH-WIN_W+1, i.e. 238 at defaults. No windows straddle a row boundary: the first WIN_W-1 beats of each row refill the store without asserting valid. The shift registers are not cleared at row start.
- line_end = window_valid for beat k = IMAGE_WIDTH-1.
- frame_end = line_end AND row_cnt = IMAGE_HEIGHT-LINE_NUM. It coincides with line_end in the same cycle.
- Back-to-back rows with datain_valid held high are supported at full rate, one window per cycle, with no bubble other than the WIN_W-1 refill beats.
- Reset mid-line: the next cycle's outputs are 0. The following valid beat is treated as column 0 of row 0.

Optional Feature:
- Macro: LINE_WINDOW_COORD_EN.
- Defined: adds two outputs.
  - win_x, $clog2(IMAGE_WIDTH) bits: column index of the window's leftmost column (= k-WIN_W+1).
  - win_y, $clog2(IMAGE_HEIGHT) bits: row_cnt of that window.
  - Both are registered alongside window_out, 0 on reset, and hold when window_valid=0.
- Not defined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with datain_valid toggling -> window_out=0 and window_valid/line_end/frame_end=0 throughout, and 1 cycle after release.
- Single row: lanes r=0..2 carry r*1000+j for j=1..240, continuous valid -> 238 windows.
  - First window appears 1 cycle after the beat j=3, with c0={1,1001,2001}, c2={3,1003,2003}.
  - Last window has columns 238..240 with line_end=1.
- Gapped input: same row with datain_valid low every other cycle -> identical 238-window sequence; window_valid never high in a gap+1 cycle.
- Row boundary: two consecutive rows, continuous valid -> 476 windows. No window contains j=239/240 together with next-row j=1. There is a 2-cycle valid gap after each line_end.
- Frame: 10 aligned rows at defaults -> frame_end exactly once, on row 9's last window. The next row restarts row_cnt=0 (win_y=0 with LINE_WINDOW_COORD_EN).
- Mid-line reset: assert rst after beat j=100 -> outputs 0 next cycle. A fresh row j=1..240 then yields exactly 238 windows, with first window columns 1..3.

Source files
------------

// File: rtl/line_window_gen.sv
// line_window_gen: shifts aligned columns into a LINE_NUM x WIN_W pixel window with valid/line/frame markers.
// Optional win_x/win_y coordinate outputs when LINE_WINDOW_COORD_EN is defined.
module line_window_gen #(
  parameter int DATA_WIDTH   = 14,
  parameter int LINE_NUM     = 3,
  parameter int WIN_W        = 3,
  parameter int IMAGE_WIDTH  = 240,
  parameter int IMAGE_HEIGHT = 12
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [LINE_NUM*DATA_WIDTH-1:0]       data_in,
  input  logic                                datain_valid,
  output logic [LINE_NUM*WIN_W*DATA_WIDTH-1:0] window_out,
  output logic                                window_valid,
  output logic                                line_end,
  output logic                                frame_end
`ifdef LINE_WINDOW_COORD_EN
  ,
  output logic [$clog2(IMAGE_WIDTH)-1:0]      win_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]     win_y
`endif
);
  localparam int LW = LINE_NUM*DATA_WIDTH;
  localparam int OW = WIN_W*LW;
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  // column c occupies bits [c*LW +: LW], so the store already has window_out's layout
  logic [OW-1:0] col_q, col_d, window_q, window_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          valid_q, valid_d, line_end_q, line_end_d, frame_end_q, frame_end_d;
  logic          col_last, row_last, win_beat;
  always_comb begin
    col_last    = col_cnt_q == CW'(IMAGE_WIDTH-1);
    row_last    = row_cnt_q == RW'(IMAGE_HEIGHT-LINE_NUM);
    win_beat    = datain_valid && col_cnt_q >= CW'(WIN_W-1);
    col_d       = datain_valid ? {data_in, col_q[OW-1:LW]} : col_q;
    col_cnt_d   = datain_valid ? (col_last ? '0 : col_cnt_q + CW'(1)) : col_cnt_q;
    row_cnt_d   = (datain_valid && col_last) ? (row_last ? '0 : row_cnt_q + RW'(1)) : row_cnt_q;
    window_d    = win_beat ? col_d : window_q;
    valid_d     = win_beat;
    line_end_d  = win_beat && col_last;
    frame_end_d = win_beat && col_last && row_last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      window_q    <= '0;
      valid_q     <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      window_q    <= window_d;
      valid_q     <= valid_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end
  assign window_out   = window_q;
  assign window_valid = valid_q;
  assign line_end     = line_end_q;
  assign frame_end    = frame_end_q;
`ifdef LINE_WINDOW_COORD_EN
  logic [CW-1:0] x_q, x_d;
  logic [RW-1:0] y_q, y_d;
  always_comb begin
    x_d = win_beat ? col_cnt_q - CW'(WIN_W-1) : x_q;
    y_d = win_beat ? row_cnt_q : y_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign win_x = x_q;
  assign win_y = y_q;
`endif
endmodule

// File: tb/tb_line_window_gen.sv
// tb_line_window_gen: directed bench for line_window_gen; rows carry lane r = r*1000+j for column j.
module tb_line_window_gen;
  localparam int DW = 14, LN = 3, WW = 3, IW = 240, IH = 12;
  localparam int LW = LN*DW, OW = LN*WW*DW, CW = $clog2(IW), RW = $clog2(IH);
  logic          clk = 1'b0, rst = 1'b1, datain_valid = 1'b0;
  logic [LW-1:0] data_in = '0;
  logic [OW-1:0] window_out;
  logic          window_valid, line_end, frame_end;
`ifdef LINE_WINDOW_COORD_EN
  logic [CW-1:0] win_x;
  logic [RW-1:0] win_y;
`endif
  int vectors = 0, miscompares = 0, win_total = 0, fe_count = 0;
  logic [OW-1:0] exp_hold = '0;
  line_window_gen #(.DATA_WIDTH(DW), .LINE_NUM(LN), .WIN_W(WW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .datain_valid(datain_valid),
    .window_out(window_out), .window_valid(window_valid), .line_end(line_end), .frame_end(frame_end)
`ifdef LINE_WINDOW_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [LW-1:0] col_of(input int j);
    logic [LW-1:0] v;
    for (int r = 0; r < LN; r++) v[r*DW +: DW] = DW'(r*1000 + j);
    return v;
  endfunction
  function automatic logic [OW-1:0] win_of(input int j);
    logic [OW-1:0] w;
    for (int c = 0; c < WW; c++) w[c*LW +: LW] = col_of(j - WW + 1 + c);
    return w;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    datain_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_hold = '0;
  endtask
  // Sends beats j=1..nbeats (gap idle cycles after each) and checks every output cycle.
  task automatic drive_row(input string tag, input int gap, input int y, input bit last_row, input int nbeats);
    int nwin = 0;
    for (int j = 1; j <= nbeats; j++) begin
      data_in = col_of(j);
      datain_valid = 1'b1;
      tick();
      vectors++;
      if (window_valid !== (j >= WW)) begin
        miscompares++;
        $display("FAIL %s_valid j=%0d got %b want %b", tag, j, window_valid, j >= WW);
      end
      if (j >= WW) begin
        exp_hold = win_of(j);
        nwin++;
        win_total++;
      end
      vectors++;
      if (window_out !== exp_hold) begin
        miscompares++;
        $display("FAIL %s_window j=%0d got %h want %h", tag, j, window_out, exp_hold);
      end
      vectors++;
      if (line_end !== (j == IW)) begin
        miscompares++;
        $display("FAIL %s_line_end j=%0d got %b want %b", tag, j, line_end, j == IW);
      end
      vectors++;
      if (frame_end !== (j == IW && last_row)) begin
        miscompares++;
        $display("FAIL %s_frame_end j=%0d got %b want %b", tag, j, frame_end, j == IW && last_row);
      end
      if (frame_end === 1'b1) fe_count++;
`ifdef LINE_WINDOW_COORD_EN
      if (j >= WW) begin
        vectors++;
        if (win_x !== CW'(j - WW) || win_y !== RW'(y)) begin
          miscompares++;
          $display("FAIL %s_coord j=%0d got %0d,%0d want %0d,%0d", tag, j, win_x, win_y, j - WW, y);
        end
      end
`endif
      for (int g = 0; g < gap; g++) begin
        data_in = '1;
        datain_valid = 1'b0;
        tick();
        vectors++;
        if ({window_valid, line_end, frame_end} !== 3'b000) begin
          miscompares++;
          $display("FAIL %s_gap_flags j=%0d got %b want 000", tag, j, {window_valid, line_end, frame_end});
        end
        vectors++;
        if (window_out !== exp_hold) begin
          miscompares++;
          $display("FAIL %s_gap_hold j=%0d got %h want %h", tag, j, window_out, exp_hold);
        end
      end
    end
    if (nbeats == IW) begin
      vectors++;
      if (nwin !== IW - WW + 1) begin
        miscompares++;
        $display("FAIL %s_count got %0d want %0d", tag, nwin, IW - WW + 1);
      end
    end
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst = (i < 2);
      datain_valid = (i == 0);
      data_in = col_of(5);
      tick();
      vectors++;
      if (window_out !== '0 || {window_valid, line_end, frame_end} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got %h/%b want 0/000", i, window_out, {window_valid, line_end, frame_end});
      end
`ifdef LINE_WINDOW_COORD_EN
      vectors++;
      if (win_x !== '0 || win_y !== '0) begin
        miscompares++;
        $display("FAIL reset_coord cyc=%0d got %0d,%0d want 0,0", i, win_x, win_y);
      end
`endif
    end
    exp_hold = '0;
  endtask
  task automatic test_single_row();
    do_reset();
    drive_row("single", 0, 0, 1'b0, IW);
  endtask
  task automatic test_gapped();
    do_reset();
    drive_row("gapped", 1, 0, 1'b0, IW);
  endtask
  task automatic test_row_boundary();
    do_reset();
    win_total = 0;
    drive_row("row0", 0, 0, 1'b0, IW);
    drive_row("row1", 0, 1, 1'b0, IW);
    vectors++;
    if (win_total !== 2*(IW - WW + 1)) begin
      miscompares++;
      $display("FAIL boundary_count got %0d want %0d", win_total, 2*(IW - WW + 1));
    end
  endtask
  task automatic test_frame();
    do_reset();
    fe_count = 0;
    for (int y = 0; y <= IH - LN; y++) drive_row("frame", 0, y, y == IH - LN, IW);
    drive_row("frame_wrap", 0, 0, 1'b0, IW);
    vectors++;
    if (fe_count !== 1) begin
      miscompares++;
      $display("FAIL frame_end_count got %0d want 1", fe_count);
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    drive_row("mid_pre", 0, 0, 1'b0, 100);
    rst = 1'b1;
    datain_valid = 1'b1;
    data_in = col_of(101);
    tick();
    vectors++;
    if (window_out !== '0 || {window_valid, line_end, frame_end} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_reset got %h/%b want 0/000", window_out, {window_valid, line_end, frame_end});
    end
    rst = 1'b0;
    exp_hold = '0;
    drive_row("mid_post", 0, 0, 1'b0, IW);
  endtask
  initial begin
    test_reset();
    test_single_row();
    test_gapped();
    test_row_boundary();
    test_frame();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
